// File: rtl/alu2_sequencer.sv
// Command-side sequencer for the alu2 opcode interface: streams operand pairs into
// alu2 as a multiply-accumulate job and reads back the 2*DATA_WIDTH dot product.
module alu2_sequencer #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [COUNT_WIDTH-1:0]  length,
   input  logic                    in_valid,
   input  logic [DATA_WIDTH-1:0]   in_a,
   input  logic [DATA_WIDTH-1:0]   in_b,
   output logic                    in_ready,
   output logic [3:0]              alu_opcode,
   output logic [DATA_WIDTH-1:0]   alu_data_in,
   input  logic [DATA_WIDTH-1:0]   alu_data_out,
   output logic [2*DATA_WIDTH-1:0] result,
   output logic                    result_valid,
   output logic                    busy
);

   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_REGA  = 4'd1;
   localparam logic [3:0] OP_REGB  = 4'd2;
   localparam logic [3:0] OP_MULT  = 4'd3;
   localparam logic [3:0] OP_ACC   = 4'd4;
   localparam logic [3:0] OP_MSB   = 4'd5;
   localparam logic [3:0] OP_LSB   = 4'd6;
   localparam logic [3:0] OP_RESET = 4'd7;

   typedef enum logic [3:0] {
      S_IDLE,
      S_CLR,
      S_WAIT,
      S_LD_A,
      S_LD_B,
      S_MUL,
      S_ACC,
      S_RD_MSB,
      S_RD_LSB,
      S_CAP,
      S_DONE
   } state_t;

   state_t                   state_q;
   state_t                   state_d;
   logic [COUNT_WIDTH-1:0]   cnt_q;
   logic [DATA_WIDTH-1:0]    aHold_q;
   logic [DATA_WIDTH-1:0]    bHold_q;
   logic [3:0]               opcode_q;
   logic [DATA_WIDTH-1:0]    dataIn_q;
   logic                     inReady_q;
   logic                     busy_q;
   logic                     resultValid_q;
   logic [2*DATA_WIDTH-1:0]  result_q;

   function automatic logic [3:0] opcodeFor(input state_t s);
      case (s)
         S_CLR:    opcodeFor = OP_RESET;
         S_LD_A:   opcodeFor = OP_REGA;
         S_LD_B:   opcodeFor = OP_REGB;
         S_MUL:    opcodeFor = OP_MULT;
         S_ACC:    opcodeFor = OP_ACC;
         S_RD_MSB: opcodeFor = OP_MSB;
         S_RD_LSB: opcodeFor = OP_LSB;
         default:  opcodeFor = OP_NOP;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_CLR;
         S_CLR:    state_d = (cnt_q == '0) ? S_RD_MSB : S_WAIT;
         S_WAIT:   if (in_valid) state_d = S_LD_A;
         S_LD_A:   state_d = S_LD_B;
         S_LD_B:   state_d = S_MUL;
         S_MUL:    state_d = S_ACC;
         S_ACC:    state_d = (cnt_q == COUNT_WIDTH'(1)) ? S_RD_MSB : S_WAIT;
         S_RD_MSB: state_d = S_RD_LSB;
         S_RD_LSB: state_d = S_CAP;
         S_CAP:    state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so each one lines up with the
   // state it belongs to; alu2 returns read data one cycle after MSB/LSB.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         aHold_q       <= '0;
         bHold_q       <= '0;
         opcode_q      <= OP_NOP;
         dataIn_q      <= '0;
         inReady_q     <= 1'b0;
         busy_q        <= 1'b0;
         resultValid_q <= 1'b0;
         result_q      <= '0;
      end else begin
         state_q <= state_d;

         case (state_q)
            S_IDLE:   if (start) cnt_q <= length;
            S_WAIT: begin
               if (in_valid) begin
                  aHold_q <= in_a;
                  bHold_q <= in_b;
               end
            end
            S_ACC:    cnt_q <= cnt_q - COUNT_WIDTH'(1);
            S_RD_LSB: result_q[2*DATA_WIDTH-1:DATA_WIDTH] <= alu_data_out;
            S_CAP:    result_q[DATA_WIDTH-1:0] <= alu_data_out;
            default:  ;
         endcase

         opcode_q      <= opcodeFor(state_d);
         inReady_q     <= (state_d == S_WAIT);
         busy_q        <= (state_d != S_IDLE);
         resultValid_q <= (state_d == S_DONE);

         // LD_A is only entered on a handshake, so in_a is the operand being captured.
         case (state_d)
            S_LD_A:  dataIn_q <= in_a;
            S_LD_B:  dataIn_q <= bHold_q;
            default: dataIn_q <= '0;
         endcase
      end
   end

   assign in_ready     = inReady_q;
   assign alu_opcode   = opcode_q;
   assign alu_data_in  = dataIn_q;
   assign result       = result_q;
   assign result_valid = resultValid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_alu2_sequencer.sv
// Self-checking bench for alu2_sequencer: a behavioural alu2 answers the opcode stream,
// and an expected per-cycle trace plus dot-product result is built from the job rules.
module tb_alu2_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic [3:0]  length;
   logic        in_valid;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        in_ready;
   logic [3:0]  alu_opcode;
   logic [7:0]  alu_data_in;
   logic [7:0]  alu_data_out;
   logic [15:0] result;
   logic        result_valid;
   logic        busy;

   int compared   = 0;
   int mismatched = 0;

   alu2_sequencer #(.DATA_WIDTH(8), .COUNT_WIDTH(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .length       (length),
      .in_valid     (in_valid),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_ready     (in_ready),
      .alu_opcode   (alu_opcode),
      .alu_data_in  (alu_data_in),
      .alu_data_out (alu_data_out),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural alu2: registers, multiplier, accumulator; reads return next cycle.
   logic [7:0]  aluA   = '0;
   logic [7:0]  aluB   = '0;
   logic [15:0] aluP   = '0;
   logic [15:0] aluAcc = '0;
   always @(posedge clk) begin
      case (alu_opcode)
         4'd1: aluA <= alu_data_in;
         4'd2: aluB <= alu_data_in;
         4'd3: aluP <= 16'(aluA) * 16'(aluB);
         4'd4: aluAcc <= aluAcc + aluP;
         4'd5: alu_data_out <= aluAcc[15:8];
         4'd6: alu_data_out <= aluAcc[7:0];
         4'd7: aluAcc <= '0;
         default: ;
      endcase
   end
   initial alu_data_out = '0;

   typedef struct packed {
      logic       rv;
      logic       rdy;
      logic [3:0] op;
      logic [7:0] din;
   } step_t;

   step_t      expQ[$];
   logic [7:0] jobA[16];
   logic [7:0] jobB[16];
   int         jobStall[16];

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   function automatic step_t mkStep(input logic rv, input logic rdy, input logic [3:0] op,
                                    input logic [7:0] din);
      step_t s;
      s.rv  = rv;
      s.rdy = rdy;
      s.op  = op;
      s.din = din;
      return s;
   endfunction

   // Expected cycle-by-cycle trace and dot product, straight from the job description.
   task automatic buildExpected(input int n, output logic [15:0] expSum);
      int sum;
      sum = 0;
      expQ.delete();
      expQ.push_back(mkStep(1'b0, 1'b0, 4'd7, 8'h00));
      for (int i = 0; i < n; i++) begin
         for (int s = 0; s <= jobStall[i]; s++) expQ.push_back(mkStep(1'b0, 1'b1, 4'd0, 8'h00));
         expQ.push_back(mkStep(1'b0, 1'b0, 4'd1, jobA[i]));
         expQ.push_back(mkStep(1'b0, 1'b0, 4'd2, jobB[i]));
         expQ.push_back(mkStep(1'b0, 1'b0, 4'd3, 8'h00));
         expQ.push_back(mkStep(1'b0, 1'b0, 4'd4, 8'h00));
         sum += int'(jobA[i]) * int'(jobB[i]);
      end
      expQ.push_back(mkStep(1'b0, 1'b0, 4'd5, 8'h00));
      expQ.push_back(mkStep(1'b0, 1'b0, 4'd6, 8'h00));
      expQ.push_back(mkStep(1'b0, 1'b0, 4'd0, 8'h00));
      expQ.push_back(mkStep(1'b1, 1'b0, 4'd0, 8'h00));
      expSum = sum[15:0];
   endtask

   // Runs one job; abortMul>0 asserts reset during that MULT occurrence.
   task automatic applyStimulus(input string name, input int n, input bit startNoise,
                                input int abortMul, output logic [15:0] expSum);
      int p;
      int stallLeft;
      int mulSeen;
      bit aborted;
      step_t e;
      buildExpected(n, expSum);
      p = 0;
      stallLeft = jobStall[0];
      mulSeen = 0;
      aborted = 0;
      @(negedge clk);
      start  = 1'b1;
      length = 4'(n);
      in_valid = 1'b0;
      for (int c = 1; c <= expQ.size(); c++) begin
         @(negedge clk);
         e = expQ[c-1];
         checkOutput({name, "_trace"}, {17'd0, busy, result_valid, in_ready, alu_opcode, alu_data_in},
                     {17'd0, 1'b1, e});
         if (e.rv) checkOutput({name, "_result"}, {16'd0, result}, {16'd0, expSum});
         start  = (startNoise && c != expQ.size()) ? 1'($urandom_range(0, 1)) : 1'b0;
         length = 4'($urandom);
         if (e.op == 4'd3) mulSeen++;
         if (abortMul > 0 && e.op == 4'd3 && mulSeen == abortMul) begin
            reset = 1'b1;
            in_valid = 1'b0;
            start = 1'b0;
            @(negedge clk);
            checkOutput({name, "_abort"}, {11'd0, busy, result_valid, in_ready, alu_opcode, result},
                        32'd0);
            checkOutput({name, "_abort_din"}, {24'd0, alu_data_in}, 32'd0);
            reset = 1'b0;
            aborted = 1;
            break;
         end
         if (in_ready) begin
            if (stallLeft > 0 || p >= n) begin
               in_valid = 1'b0;
               in_a = 8'($urandom);
               in_b = 8'($urandom);
               if (stallLeft > 0) stallLeft--;
            end else begin
               in_valid = 1'b1;
               in_a = jobA[p];
               in_b = jobB[p];
               p++;
               stallLeft = (p < 16) ? jobStall[p] : 0;
            end
         end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_a = 8'($urandom);
            in_b = 8'($urandom);
         end
      end
      if (!aborted) begin
         start = 1'b0;
         in_valid = 1'b0;
         @(negedge clk);
         checkOutput({name, "_idle"}, {11'd0, busy, result_valid, in_ready, alu_opcode, alu_data_in},
                     32'd0);
         checkOutput({name, "_held"}, {16'd0, result}, {16'd0, expSum});
      end
   endtask

   logic [15:0] sum;

   initial begin
      reset = 1'b1;
      start = 1'b0;
      length = '0;
      in_valid = 1'b0;
      in_a = '0;
      in_b = '0;
      for (int i = 0; i < 16; i++) begin
         jobA[i] = '0;
         jobB[i] = '0;
         jobStall[i] = 0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state", {11'd0, busy, result_valid, in_ready, alu_opcode, result}, 32'd0);
      checkOutput("reset_din", {24'd0, alu_data_in}, 32'd0);
      reset = 1'b0;

      jobA[0] = 8'h0F; jobB[0] = 8'h1A;
      jobA[1] = 8'h26; jobB[1] = 8'h05;
      jobA[2] = 8'h03; jobB[2] = 8'h11;
      applyStimulus("t1_len3", 3, 1'b0, 0, sum);
      checkOutput("t1_const", {16'd0, result}, 32'h0277);

      for (int i = 0; i < 3; i++) jobStall[i] = 3;
      applyStimulus("t2_stall", 3, 1'b0, 0, sum);
      checkOutput("t2_const", {16'd0, result}, 32'h0277);
      for (int i = 0; i < 3; i++) jobStall[i] = 0;

      applyStimulus("t3_len0", 0, 1'b0, 0, sum);
      checkOutput("t3_const", {16'd0, result}, 32'h0000);

      jobA[0] = 8'hFF; jobB[0] = 8'hFF;
      jobA[1] = 8'hFF; jobB[1] = 8'hFF;
      applyStimulus("t4_wrap", 2, 1'b0, 0, sum);
      checkOutput("t4_const", {16'd0, result}, 32'hFC02);

      jobA[0] = 8'h0F; jobB[0] = 8'h1A;
      jobA[1] = 8'h26; jobB[1] = 8'h05;
      jobA[2] = 8'h03; jobB[2] = 8'h11;
      applyStimulus("t5_busy_start", 3, 1'b1, 0, sum);

      applyStimulus("t6_abort", 2, 1'b0, 2, sum);
      jobA[0] = 8'h03; jobB[0] = 8'h11;
      applyStimulus("t6_after", 1, 1'b0, 0, sum);
      checkOutput("t6_const", {16'd0, result}, 32'h0033);

      for (int j = 0; j < 25; j++) begin
         int n;
         n = $urandom_range(0, 7);
         for (int i = 0; i < 16; i++) begin
            jobA[i] = 8'($urandom);
            jobB[i] = 8'($urandom);
            jobStall[i] = $urandom_range(0, 3);
         end
         applyStimulus("rand", n, 1'($urandom_range(0, 1)), 0, sum);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
